// File: rtl/frame_bank_ctrl_if.sv
// rtl/frame_bank_ctrl_if.sv - camera, VGA and frame-memory signals of the bank controller
interface frame_bank_ctrl_if #(
  parameter int ADDR_W = 17
);
  logic              cam_frame_start;
  logic              cam_frame_done;
  logic              cam_we;
  logic [ADDR_W-1:0] cam_addr;
  logic [7:0]        cam_data;
  logic [9:0]        HCnt;
  logic [9:0]        VCnt;
  logic [ADDR_W-1:0] frame_addr;
  logic              mem_wr_en;
  logic [ADDR_W:0]   mem_wr_addr;
  logic [7:0]        mem_wr_data;
  logic [ADDR_W:0]   mem_rd_addr;
  logic              wr_bank;
  logic              rd_bank;
  logic              display_valid;
  logic              swap_pulse;
  logic [7:0]        frames_dropped;

  modport master (
    output cam_frame_start, cam_frame_done, cam_we, cam_addr, cam_data,
    output HCnt, VCnt, frame_addr,
    input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr,
    input  wr_bank, rd_bank, display_valid, swap_pulse, frames_dropped
  );

  modport slave (
    input  cam_frame_start, cam_frame_done, cam_we, cam_addr, cam_data,
    input  HCnt, VCnt, frame_addr,
    output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr,
    output wr_bank, rd_bank, display_valid, swap_pulse, frames_dropped
  );
endinterface

// File: rtl/frame_bank_ctrl.sv
// rtl/frame_bank_ctrl.sv - ping-pong QVGA frame bank controller with tear-free swap at a fixed VGA line
module frame_bank_ctrl #(
  parameter int ADDR_W       = 17,
  parameter int FRAME_PIXELS = 76800,
  parameter int SWAP_LINE    = 480
) (
  input logic              clk25,
  input logic              reset,
  frame_bank_ctrl_if.slave bus
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DROP    = 2'd2;

  localparam logic [ADDR_W-1:0] PIXEL_LIMIT = ADDR_W'(FRAME_PIXELS);
  localparam logic [9:0]        SWAP_V      = 10'(SWAP_LINE);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            pending;
  logic            pending_eff;
  logic            pending_nxt;
  logic            wr_bank_q;
  logic            display_valid_q;
  logic            swap_pulse_q;
  logic [7:0]      dropped_q;
  logic            wr_en_q;
  logic [ADDR_W:0] wr_addr_q;
  logic [7:0]      wr_data_q;
  logic            swap_point;
  logic            done_capture;
  logic            do_swap;
  logic            drop_inc;
  logic            wr_fire;

  // A done arriving on the swap line counts as pending in that same cycle,
  // and a start on the swap line sees pending already cleared by the swap.
  always_comb begin
    swap_point   = (bus.VCnt == SWAP_V) && (bus.HCnt == 10'd0);
    done_capture = (state == ST_CAPTURE) && bus.cam_frame_done;
    pending_eff  = pending | done_capture;
    do_swap      = swap_point & pending_eff;
    pending_nxt  = pending_eff & ~do_swap;
    state_nxt    = state;
    drop_inc     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cam_frame_start)
          state_nxt = pending_nxt ? ST_DROP : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (bus.cam_frame_done)
          state_nxt = ST_IDLE;
      end
      ST_DROP: begin
        if (bus.cam_frame_done) begin
          drop_inc  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (bus.cam_frame_start) begin
          drop_inc  = 1'b1;
          state_nxt = pending_nxt ? ST_DROP : ST_CAPTURE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    wr_fire = bus.cam_we
            && ((state == ST_CAPTURE) || (state_nxt == ST_CAPTURE))
            && (bus.cam_addr < PIXEL_LIMIT);
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      state           <= ST_IDLE;
      pending         <= 1'b0;
      wr_bank_q       <= 1'b0;
      display_valid_q <= 1'b0;
      swap_pulse_q    <= 1'b0;
      dropped_q       <= 8'd0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= 8'd0;
    end else begin
      state        <= state_nxt;
      pending      <= pending_nxt;
      swap_pulse_q <= do_swap;
      if (do_swap) begin
        wr_bank_q       <= ~wr_bank_q;
        display_valid_q <= 1'b1;
      end
      if (drop_inc && (dropped_q != 8'hFF))
        dropped_q <= dropped_q + 8'd1;
      wr_en_q <= wr_fire;
      // Address uses the bank owned before this cycle's swap
      if (wr_fire) begin
        wr_addr_q <= {wr_bank_q, bus.cam_addr};
        wr_data_q <= bus.cam_data;
      end
    end
  end

  assign bus.mem_wr_en      = wr_en_q;
  assign bus.mem_wr_addr    = wr_addr_q;
  assign bus.mem_wr_data    = wr_data_q;
  assign bus.mem_rd_addr    = {~wr_bank_q, bus.frame_addr};
  assign bus.wr_bank        = wr_bank_q;
  assign bus.rd_bank        = ~wr_bank_q;
  assign bus.display_valid  = display_valid_q;
  assign bus.swap_pulse     = swap_pulse_q;
  assign bus.frames_dropped = dropped_q;
endmodule
